// File: rtl/spell_bus_master.sv
// ---------------------------------------------------------------------------
// spell_bus_master
//
// Single-outstanding initiator for the spell peripheral bus. One command is
// accepted, issued to the bus as a one-cycle bus_select strobe, and then
// waited on. The reply is either the peripheral's data or a timeout abort.
// It is presented on the response channel until it is taken.
//
// Parameters
//   TIMEOUT        number of WAIT cycles without bus_data_ready before the
//                  transaction is aborted (legal range 1..15)
//
// Ports
//   clock          sole clock, rising edge
//   reset          synchronous, active-low
//   cmd_valid      in   command offered
//   cmd_ready      out  command accepted this edge when cmd_valid is also 1
//   cmd_write      in   1 = write, 0 = read
//   cmd_addr [7:0] in   bus address
//   cmd_wdata[7:0] in   write data
//   rsp_valid      out  response available
//   rsp_ready      in   response consumed this edge when rsp_valid is also 1
//   rsp_rdata[7:0] out  read data (0x00 on timeout)
//   rsp_timeout    out  1 = transaction aborted by timeout
//   bus_select     out  one-cycle access strobe
//   bus_addr [7:0] out  bus address, stable from strobe until the reply
//   bus_wdata[7:0] out  bus write data, stable likewise
//   bus_write      out  bus direction, stable likewise
//   bus_rdata[7:0] in   peripheral read data
//   bus_data_ready in   peripheral reply strobe
//   timeout_count[7:0] out  timed-out transactions since reset, saturating
//   o_dbg_state[1:0]   out  current FSM state (IDLE=0 STROBE=1 WAIT=2 RESP=3)
//
// Handshake rule for both channels: a transfer happens at a rising edge
// where valid and ready are both 1. The master holds rsp_valid and the
// response fields unchanged until that edge. cmd_ready does not depend on
// cmd_valid.
// ---------------------------------------------------------------------------
module spell_bus_master #(
   parameter int TIMEOUT = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_rdata,
   output logic       rsp_timeout,
   output logic       bus_select,
   output logic [7:0] bus_addr,
   output logic [7:0] bus_wdata,
   output logic       bus_write,
   input  logic [7:0] bus_rdata,
   input  logic       bus_data_ready,
   output logic [7:0] timeout_count,
   output logic [1:0] o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STROBE = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   // Last wait-counter value before an abort: TIMEOUT WAIT cycles in total.
   localparam logic [3:0] LP_WAIT_LAST = 4'(TIMEOUT - 1);

   state_t     r_state;
   logic       r_bus_select;
   logic [7:0] r_bus_addr;
   logic [7:0] r_bus_wdata;
   logic       r_bus_write;
   logic       r_rsp_valid;
   logic [7:0] r_rsp_rdata;
   logic       r_rsp_timeout;
   logic [3:0] r_wait_cnt;
   logic [7:0] r_timeout_count;

   state_t     w_state;
   logic       w_bus_select;
   logic [7:0] w_bus_addr;
   logic [7:0] w_bus_wdata;
   logic       w_bus_write;
   logic       w_rsp_valid;
   logic [7:0] w_rsp_rdata;
   logic       w_rsp_timeout;
   logic [3:0] w_wait_cnt;
   logic [7:0] w_timeout_count;
   logic       w_cmd_ready;

   // cmd_ready is the one output that is not a flop. It must drop while
   // reset is low, and it must drop while a stale bus_data_ready is present,
   // in the same cycle those inputs change. The FSM term is still registered.
   assign w_cmd_ready = (r_state == ST_IDLE) && !bus_data_ready && reset;

   always_comb begin
      w_state         = r_state;
      w_bus_select    = 1'b0;
      w_bus_addr      = r_bus_addr;
      w_bus_wdata     = r_bus_wdata;
      w_bus_write     = r_bus_write;
      w_rsp_valid     = r_rsp_valid;
      w_rsp_rdata     = r_rsp_rdata;
      w_rsp_timeout   = r_rsp_timeout;
      w_wait_cnt      = r_wait_cnt;
      w_timeout_count = r_timeout_count;

      case (r_state)
         ST_IDLE: begin
            if (cmd_valid && w_cmd_ready) begin
               w_bus_addr   = cmd_addr;
               w_bus_wdata  = cmd_wdata;
               w_bus_write  = cmd_write;
               w_bus_select = 1'b1;
               w_state      = ST_STROBE;
            end
         end

         // The strobe lasts exactly one cycle. w_bus_select defaults to 0
         // here, so the peripheral sees each access once.
         ST_STROBE: begin
            w_wait_cnt = 4'd0;
            w_state    = ST_WAIT;
         end

         ST_WAIT: begin
            if (bus_data_ready) begin
               w_rsp_rdata   = bus_rdata;
               w_rsp_timeout = 1'b0;
               w_rsp_valid   = 1'b1;
               w_state       = ST_RESP;
            end else if (r_wait_cnt == LP_WAIT_LAST) begin
               w_rsp_rdata   = 8'h00;
               w_rsp_timeout = 1'b1;
               w_rsp_valid   = 1'b1;
               if (r_timeout_count != 8'hFF) begin
                  w_timeout_count = r_timeout_count + 8'd1;
               end
               w_state       = ST_RESP;
            end else begin
               w_wait_cnt = r_wait_cnt + 4'd1;
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               w_rsp_valid = 1'b0;
               w_state     = ST_IDLE;
            end
         end

         default: begin
            w_rsp_valid = 1'b0;
            w_state     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state         <= ST_IDLE;
         r_bus_select    <= 1'b0;
         r_bus_addr      <= 8'h00;
         r_bus_wdata     <= 8'h00;
         r_bus_write     <= 1'b0;
         r_rsp_valid     <= 1'b0;
         r_rsp_rdata     <= 8'h00;
         r_rsp_timeout   <= 1'b0;
         r_wait_cnt      <= 4'd0;
         r_timeout_count <= 8'h00;
      end else begin
         r_state         <= w_state;
         r_bus_select    <= w_bus_select;
         r_bus_addr      <= w_bus_addr;
         r_bus_wdata     <= w_bus_wdata;
         r_bus_write     <= w_bus_write;
         r_rsp_valid     <= w_rsp_valid;
         r_rsp_rdata     <= w_rsp_rdata;
         r_rsp_timeout   <= w_rsp_timeout;
         r_wait_cnt      <= w_wait_cnt;
         r_timeout_count <= w_timeout_count;
      end
   end

   assign cmd_ready     = w_cmd_ready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_timeout   = r_rsp_timeout;
   assign bus_select    = r_bus_select;
   assign bus_addr      = r_bus_addr;
   assign bus_wdata     = r_bus_wdata;
   assign bus_write     = r_bus_write;
   assign timeout_count = r_timeout_count;
   assign o_dbg_state   = r_state;

endmodule

// File: doc/spell_bus_master.md
SPELL_BUS_MASTER -- requirements
Module: spell_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8, max WAIT cycles without bus_data_ready before abort; legal range 1..15.
REQ-002 SHALL have port clock  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_addr in 8, cmd_wdata in 8: command channel, valid/ready handshake.
REQ-005 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out 8, rsp_timeout out 1: response channel, valid/ready handshake.
REQ-006 SHALL have ports bus_select out 1, bus_addr out 8, bus_wdata out 8, bus_write out 1, bus_rdata in 8, bus_data_ready in 1: initiator side of the spell peripheral bus.
REQ-007 SHALL have port timeout_count  output  8  number of timed-out transactions since reset.

Function
REQ-008 SHALL implement states IDLE, STROBE, WAIT, RESP; all outputs registered.
REQ-009 SHALL drive cmd_ready=1 only in IDLE while bus_data_ready=0; otherwise 0.
REQ-010 SHALL, on cmd_valid&&cmd_ready at an edge, latch cmd_write/addr/wdata onto bus_write/bus_addr/bus_wdata and enter STROBE.
REQ-011 SHALL assert bus_select for exactly one cycle (STROBE only), never longer, so a peripheral performs each access exactly once (PIN write toggles once).
REQ-012 SHALL hold bus_addr, bus_wdata, bus_write stable from STROBE until leaving WAIT.
REQ-013 SHALL leave STROBE for WAIT unconditionally after one cycle, clearing the wait counter to 0.
REQ-014 SHALL in WAIT sample bus_data_ready each edge; if 1, capture bus_rdata into rsp_rdata, clear rsp_timeout, enter RESP.
REQ-015 SHALL in WAIT, if bus_data_ready=0, increment the 4-bit wait counter; when counter equals TIMEOUT-1 with bus_data_ready=0, set rsp_rdata=0x00, rsp_timeout=1, enter RESP (exactly TIMEOUT WAIT cycles).
REQ-016 SHALL, on timeout, increment timeout_count, saturating at 0xFF.
REQ-017 SHALL assert rsp_valid throughout RESP, holding rsp_rdata/rsp_timeout stable; on rsp_valid&&rsp_ready return to IDLE.
REQ-018 SHALL ignore bus_data_ready and bus_rdata in IDLE, STROBE and RESP.
REQ-019 SHALL give minimum latency: accept at edge E0, bus_select high E0-E1, ready sampled E2, rsp_valid visible after E2.
REQ-020 SHALL, with writes, return rsp_rdata as sampled from bus_rdata (0x00 from compliant peripherals).
REQ-021 SHALL produce no bus_select while rsp_valid is pending (no pipelining; one outstanding transaction).

Reset
REQ-022 SHALL, on reset=0 at a clock edge, enter IDLE and clear bus_select, bus_write, bus_addr, bus_wdata, rsp_valid, rsp_rdata, rsp_timeout, wait counter, timeout_count to 0.
REQ-023 SHALL, on reset mid-transaction, abandon it with no response; cmd_ready=1 on first cycle after reset release if bus_data_ready=0.
REQ-024 SHALL hold cmd_ready=0 while reset=0.

Verification
REQ-025 Read: cmd addr 0x36 write=0, peripheral returns 0xA5 one cycle after select -> bus_select high exactly 1 cycle, rsp_valid 2 edges after accept, rsp_rdata=0xA5, rsp_timeout=0.
REQ-026 Write: cmd addr 0x38 wdata 0x3C write=1 -> bus_write=1, bus_wdata=0x3C, single select pulse, peripheral PORT=0x3C, rsp_rdata=0x00.
REQ-027 Timeout: silent peripheral, TIMEOUT=8 -> rsp_valid after exactly 8 WAIT cycles, rsp_timeout=1, rsp_rdata=0x00, timeout_count=1; 256 timeouts -> timeout_count=0xFF.
REQ-028 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, no bus_select; rsp_ready=1 -> IDLE next edge.
REQ-029 Reset in WAIT: reset=0 one edge -> all outputs 0, no rsp_valid; new command then completes normally.
REQ-030 Back-to-back: cmd_valid held, two commands, rsp_ready=1 -> two single-cycle select pulses, responses in order, no pulse before first RESP handshake.
